// File: rtl/regfile_seq.sv
// Sequencer that drives an external 8 x 13-bit register file.
// One command is accepted in IDLE. A normal command runs one EXEC cycle,
// and CLR runs eight clearing writes. Both finish with a one-cycle DONE in FIN.
// WR, WA, LD_DATA, DONE and CMD_READY are decoded from the state and gated by CLRN.
// This lets a reset cycle suppress a write at once, including mid-command.
module regfile_seq (
    input  logic        CLK,
    input  logic        CLRN,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [2:0]  CMD_OP,
    input  logic [2:0]  CMD_DST,
    input  logic [2:0]  CMD_SRCA,
    input  logic [2:0]  CMD_SRCB,
    input  logic [12:0] CMD_IMM,
    output logic [2:0]  RP,
    output logic [2:0]  RQ,
    input  logic [12:0] DATAP,
    input  logic [12:0] DATAQ,
    output logic [2:0]  WA,
    output logic [12:0] LD_DATA,
    output logic        WR,
    output logic [12:0] RESULT,
    output logic        FLAG_Z,
    output logic        FLAG_C,
    output logic        DONE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_LDI = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    logic [1:0]  state_reg, state_next;
    logic [2:0]  op_reg, dst_reg, srca_reg, srcb_reg, k_reg;
    logic [12:0] imm_reg, result_reg;
    logic        flag_z_reg, flag_c_reg;

    logic [13:0] sum_ext;
    logic [12:0] alu_res;
    logic        alu_c;
    logic        op_writes;
    logic        op_sets_flags;

    // The read addresses always present the latched sources.
    // This makes the operands valid combinationally throughout EXEC.
    assign RP     = srca_reg;
    assign RQ     = srcb_reg;
    assign RESULT = result_reg;
    assign FLAG_Z = flag_z_reg;
    assign FLAG_C = flag_c_reg;

    assign op_writes     = (op_reg == OP_MOV) || (op_reg == OP_LDI) || (op_reg == OP_ADD) ||
                           (op_reg == OP_SUB) || (op_reg == OP_INC);
    assign op_sets_flags = (op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                           (op_reg == OP_CMP) || (op_reg == OP_INC);

    // ALU: the result and carry/borrow come from this cycle's read data.
    // The write lands at the edge ending EXEC, so SRCA == DST still reads the old value.
    always_comb begin
        sum_ext = 14'd0;
        alu_res = 13'd0;
        alu_c   = 1'b0;
        case (op_reg)
            OP_MOV: alu_res = DATAP;
            OP_LDI: alu_res = imm_reg;
            OP_ADD: begin
                sum_ext = {1'b0, DATAP} + {1'b0, DATAQ};
                alu_res = sum_ext[12:0];
                alu_c   = sum_ext[13];
            end
            OP_SUB, OP_CMP: begin
                alu_res = DATAP - DATAQ;
                alu_c   = (DATAP < DATAQ);
            end
            OP_INC: begin
                sum_ext = {1'b0, DATAP} + 14'd1;
                alu_res = sum_ext[12:0];
                alu_c   = sum_ext[13];
            end
            default: alu_res = 13'd0;
        endcase
    end

    // Next-state logic. Commands are looked at only in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (CMD_VALID) state_next = (CMD_OP == OP_CLR) ? ST_CLR : ST_EXEC;
            ST_EXEC: state_next = ST_FIN;
            ST_CLR:  if (k_reg == 3'd7) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Register-file write port and handshake outputs, all forced low while in reset.
    always_comb begin
        CMD_READY = CLRN && (state_reg == ST_IDLE);
        DONE      = CLRN && (state_reg == ST_FIN);
        WR        = 1'b0;
        WA        = 3'd0;
        LD_DATA   = 13'd0;
        if (CLRN) begin
            if (state_reg == ST_EXEC && op_writes) begin
                WR      = 1'b1;
                WA      = dst_reg;
                LD_DATA = alu_res;
            end else if (state_reg == ST_CLR) begin
                WR      = 1'b1;
                WA      = k_reg;
                LD_DATA = 13'd0;
            end
        end
    end

    // State, latched command fields, clear counter, and result/flag registers.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            state_reg  <= ST_IDLE;
            op_reg     <= 3'd0;
            dst_reg    <= 3'd0;
            srca_reg   <= 3'd0;
            srcb_reg   <= 3'd0;
            imm_reg    <= 13'd0;
            k_reg      <= 3'd0;
            result_reg <= 13'd0;
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && CMD_VALID) begin
                op_reg   <= CMD_OP;
                dst_reg  <= CMD_DST;
                srca_reg <= CMD_SRCA;
                srcb_reg <= CMD_SRCB;
                imm_reg  <= CMD_IMM;
            end
            k_reg <= (state_reg == ST_CLR) ? k_reg + 3'd1 : 3'd0;
            if (state_reg == ST_EXEC) begin
                if (op_reg != OP_NOP) result_reg <= alu_res;
                if (op_sets_flags) begin
                    flag_z_reg <= (alu_res == 13'd0);
                    flag_c_reg <= alu_c;
                end
            end
        end
    end

endmodule
